// File: rtl/alu_md_pkg.sv
// Shared encodings for the ALU control / multiply-divide block.
// Defining ALU_MD_DIV_EN enables the DIV/DIVU instructions and the DIV state.
package alu_md_pkg;

    localparam logic [5:0] FUNC_SLL   = 6'h00;
    localparam logic [5:0] FUNC_SRL   = 6'h02;
    localparam logic [5:0] FUNC_SRA   = 6'h03;
    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_JALR  = 6'h09;
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h22;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_XOR   = 6'h26;
    localparam logic [5:0] FUNC_NOR   = 6'h27;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

    localparam logic [3:0] ALUOp_R    = 4'd0;
    localparam logic [3:0] ALUOp_ADD  = 4'd1;
    localparam logic [3:0] ALUOp_SUB  = 4'd2;
    localparam logic [3:0] ALUOp_AND  = 4'd3;
    localparam logic [3:0] ALUOp_OR   = 4'd4;
    localparam logic [3:0] ALUOp_XOR  = 4'd5;
    localparam logic [3:0] ALUOp_SLT  = 4'd6;
    localparam logic [3:0] ALUOp_SLTU = 4'd7;
    localparam logic [3:0] ALUOp_LUI  = 4'd8;
    localparam logic [3:0] ALUOp_ADDU = 4'd9;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDU = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SUBU = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_SLL  = 4'd11;
    localparam logic [3:0] OP_SRL  = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13;
    localparam logic [3:0] OP_LUI  = 4'd14;

    localparam logic [1:0] MF_ALU = 2'b00;
    localparam logic [1:0] MF_HI  = 2'b01;
    localparam logic [1:0] MF_LO  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef ALU_MD_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } md_state_e;

    // R-type functs that belong to the multiply/divide unit and may stall
    function automatic logic is_md_funct(input logic [5:0] f);
        logic r;
        r = 1'b0;
        case (f)
            FUNC_MULT, FUNC_MULTU, FUNC_MFHI, FUNC_MFLO,
            FUNC_MTHI, FUNC_MTLO:  r = 1'b1;
`ifdef ALU_MD_DIV_EN
            FUNC_DIV, FUNC_DIVU:   r = 1'b1;
`endif
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) / restoring divide datapath, one bit per cycle.
// The divide step exists only when ALU_MD_DIV_EN is defined.
module mdu_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            run,
`ifdef ALU_MD_DIV_EN
    input  logic            div_mode,
`endif
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] acc_hi,
    output logic [XLEN-1:0] acc_lo
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   count;
    logic [XLEN-1:0] upper;
    logic [XLEN-1:0] lower;
    logic [XLEN-1:0] operand;
    logic [XLEN:0]   add_sum;
    logic [XLEN-1:0] next_upper;
    logic [XLEN-1:0] next_lower;
`ifdef ALU_MD_DIV_EN
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
`endif

    // {upper,lower} is the product register for multiply and {remainder,quotient} for divide
    always_comb begin
        add_sum    = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        next_upper = add_sum[XLEN:1];
        next_lower = {add_sum[0], lower[XLEN-1:1]};
`ifdef ALU_MD_DIV_EN
        shifted = {upper, lower[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        if (div_mode) begin
            if (!diff[XLEN]) begin
                next_upper = diff[XLEN-1:0];
                next_lower = {lower[XLEN-2:0], 1'b1};
            end else begin
                next_upper = shifted[XLEN-1:0];
                next_lower = {lower[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            upper   <= '0;
            lower   <= '0;
            operand <= '0;
        end else if (load) begin
            count   <= '0;
            upper   <= '0;
            lower   <= a;
            operand <= b;
        end else if (run) begin
            count   <= count + CW'(1);
            upper   <= next_upper;
            lower   <= next_lower;
        end
    end

    assign last   = (count == CW'(XLEN - 1));
    assign acc_hi = upper;
    assign acc_lo = lower;

endmodule

// File: rtl/alu_md_ctrl.sv
// ALU control decode plus multicycle multiply/divide FSM with HI/LO registers.
// Defining ALU_MD_DIV_EN adds DIV/DIVU support; without it only multiply is built.
module alu_md_ctrl
    import alu_md_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ALUOP_W   = 4,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [5:0]           funct,
    input  logic [ALUOP_W-1:0]   ALUOp,
    input  logic [XLEN-1:0]      rs_val,
    input  logic [XLEN-1:0]      rt_val,
    output logic [ALUCTRL_W-1:0] ALUCTRL,
    output logic                 shift,
    output logic                 RegtoPC,
    output logic                 RegPCWr,
    output logic [1:0]           mf_sel,
    output logic                 busy,
    output logic                 stall,
    output logic [XLEN-1:0]      hi,
    output logic [XLEN-1:0]      lo
);

    md_state_e         state, next_state;
    logic [3:0]        op;
    logic              is_r;
    logic              md_class;
    logic              start_mul;
    logic              start_div;
    logic              load;
    logic              run;
    logic              last;
    logic              signed_op;
    logic              neg_q;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [2*XLEN-1:0] prod_fix;
`ifdef ALU_MD_DIV_EN
    logic              div_q;
    logic              rem_neg_q;
    logic              div_zero_q;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
`endif

    assign is_r = (ALUOp == ALUOP_W'(ALUOp_R));

    always_comb begin
        op      = OP_NOP;
        shift   = 1'b0;
        RegtoPC = 1'b0;
        RegPCWr = 1'b0;
        if (is_r) begin
            case (funct)
                FUNC_ADD:  op = OP_ADD;
                FUNC_ADDU: op = OP_ADDU;
                FUNC_SUB:  op = OP_SUB;
                FUNC_SUBU: op = OP_SUBU;
                FUNC_AND:  op = OP_AND;
                FUNC_OR:   op = OP_OR;
                FUNC_XOR:  op = OP_XOR;
                FUNC_NOR:  op = OP_NOR;
                FUNC_SLT:  op = OP_SLT;
                FUNC_SLTU: op = OP_SLTU;
                FUNC_SLL:  begin op = OP_SLL; shift = 1'b1; end
                FUNC_SRL:  begin op = OP_SRL; shift = 1'b1; end
                FUNC_SRA:  begin op = OP_SRA; shift = 1'b1; end
                FUNC_JR:   RegtoPC = 1'b1;
                FUNC_JALR: begin RegtoPC = 1'b1; RegPCWr = 1'b1; end
                default:   op = OP_NOP;
            endcase
        end else begin
            case (ALUOp)
                ALUOP_W'(ALUOp_ADD):  op = OP_ADD;
                ALUOP_W'(ALUOp_ADDU): op = OP_ADDU;
                ALUOP_W'(ALUOp_SUB):  op = OP_SUB;
                ALUOP_W'(ALUOp_AND):  op = OP_AND;
                ALUOP_W'(ALUOp_OR):   op = OP_OR;
                ALUOP_W'(ALUOp_XOR):  op = OP_XOR;
                ALUOP_W'(ALUOp_SLT):  op = OP_SLT;
                ALUOP_W'(ALUOp_SLTU): op = OP_SLTU;
                ALUOP_W'(ALUOp_LUI):  op = OP_LUI;
                default:              op = OP_NOP;
            endcase
        end
    end

    assign ALUCTRL = ALUCTRL_W'(op);

    always_comb begin
        mf_sel = MF_ALU;
        if (is_r && funct == FUNC_MFHI) mf_sel = MF_HI;
        if (is_r && funct == FUNC_MFLO) mf_sel = MF_LO;
    end

    assign md_class  = valid && is_r && is_md_funct(funct);
    assign start_mul = md_class && (funct == FUNC_MULT || funct == FUNC_MULTU);
`ifdef ALU_MD_DIV_EN
    assign start_div = md_class && (funct == FUNC_DIV || funct == FUNC_DIVU);
    assign signed_op = (funct == FUNC_MULT) || (funct == FUNC_DIV);
    assign run       = (state == ST_MUL) || (state == ST_DIV);
`else
    assign start_div = 1'b0;
    assign signed_op = (funct == FUNC_MULT);
    assign run       = (state == ST_MUL);
`endif
    assign load  = (state == ST_IDLE) && (start_mul || start_div);
    assign a_mag = (signed_op && rs_val[XLEN-1]) ? -rs_val : rs_val;
    assign b_mag = (signed_op && rt_val[XLEN-1]) ? -rt_val : rt_val;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = (state != ST_IDLE);
        stall      = busy && md_class;
        case (state)
            ST_IDLE: begin
                if (start_mul)      next_state = ST_MUL;
`ifdef ALU_MD_DIV_EN
                else if (start_div) next_state = ST_DIV;
`endif
            end
            ST_MUL:  if (last) next_state = ST_DONE;
`ifdef ALU_MD_DIV_EN
            ST_DIV:  if (last) next_state = ST_DONE;
`endif
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .run      (run),
`ifdef ALU_MD_DIV_EN
        .div_mode (start_div || state == ST_DIV),
`endif
        .a        (a_mag),
        .b        (b_mag),
        .last     (last),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo)
    );

    // Operand signs are captured with the operands so later rs/rt changes cannot affect the fix-up
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q      <= 1'b0;
`ifdef ALU_MD_DIV_EN
            div_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else if (load) begin
            neg_q      <= signed_op && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
`ifdef ALU_MD_DIV_EN
            div_q      <= start_div;
            rem_neg_q  <= signed_op && rs_val[XLEN-1];
            div_zero_q <= (rt_val == '0);
`endif
        end
    end

    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
`ifdef ALU_MD_DIV_EN
    // A zero divisor leaves the dividend as remainder; the quotient is forced to all ones
    assign quot_fix = div_zero_q ? '1 : (neg_q ? -acc_lo : acc_lo);
    assign rem_fix  = rem_neg_q ? -acc_hi : acc_hi;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_DONE) begin
`ifdef ALU_MD_DIV_EN
            if (div_q) begin
                hi <= rem_fix;
                lo <= quot_fix;
            end else begin
                hi <= prod_fix[2*XLEN-1:XLEN];
                lo <= prod_fix[XLEN-1:0];
            end
`else
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
`endif
        end else if (state == ST_IDLE && md_class) begin
            if (funct == FUNC_MTHI) hi <= rs_val;
            if (funct == FUNC_MTLO) lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Self-checking bench for alu_md_ctrl (XLEN=32); DIV tests run only when ALU_MD_DIV_EN is defined.
module tb_alu_md_ctrl;
    import alu_md_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [5:0]  funct = '0;
    logic [3:0]  ALUOp = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [3:0]  ALUCTRL;
    logic        shift;
    logic        RegtoPC;
    logic        RegPCWr;
    logic [1:0]  mf_sel;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic [3:0]  exp_alu = '0;

    int          m_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    logic [63:0] prod;

    alu_md_ctrl #(.XLEN(32), .ALUOP_W(4), .ALUCTRL_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .funct   (funct),
        .ALUOp   (ALUOp),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .ALUCTRL (ALUCTRL),
        .shift   (shift),
        .RegtoPC (RegtoPC),
        .RegPCWr (RegPCWr),
        .mf_sel  (mf_sel),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [5:0] f, input logic [3:0] aop,
                                  input logic [31:0] a, input logic [31:0] b, input logic [3:0] ea);
        valid   = v;
        funct   = f;
        ALUOp   = aop;
        rs_val  = a;
        rt_val  = b;
        exp_alu = ea;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
        if (busy) begin
            errors++;
            $display("[TB] FAIL busy_timeout: busy still 1 after %0d cycles", n);
        end
    endtask

    // Which instructions the multiply/divide unit owns, straight from the instruction list
    function automatic bit model_md(input logic v, input logic [5:0] f, input logic [3:0] aop);
        bit m;
        m = (f == 6'h18) || (f == 6'h19) || (f == 6'h10) || (f == 6'h12) ||
            (f == 6'h11) || (f == 6'h13);
`ifdef ALU_MD_DIV_EN
        m = m || (f == 6'h1A) || (f == 6'h1B);
`endif
        return v && (aop == 4'd0) && m;
    endfunction

    // Reference: a started operation completes 33 edges after acceptance
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_hi  = '0;
            m_lo  = '0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (model_md(valid, funct, ALUOp)) begin
            case (funct)
                6'h11: m_hi = rs_val;
                6'h13: m_lo = rs_val;
                6'h18: begin
                    prod = 64'(longint'(int'(rs_val)) * longint'(int'(rt_val)));
                    {p_hi, p_lo} = prod;
                    m_cnt = 33;
                end
                6'h19: begin
                    prod = {32'b0, rs_val} * {32'b0, rt_val};
                    {p_hi, p_lo} = prod;
                    m_cnt = 33;
                end
`ifdef ALU_MD_DIV_EN
                6'h1A, 6'h1B: begin
                    if (rt_val == 32'd0) begin
                        p_hi = rs_val;
                        p_lo = 32'hFFFF_FFFF;
                    end else if (funct == 6'h1B) begin
                        p_lo = rs_val / rt_val;
                        p_hi = rs_val % rt_val;
                    end else if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
                        p_lo = 32'h8000_0000;
                        p_hi = 32'd0;
                    end else begin
                        p_lo = 32'(int'(rs_val) / int'(rt_val));
                        p_hi = 32'(int'(rs_val) % int'(rt_val));
                    end
                    m_cnt = 33;
                end
`endif
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("model_busy", {63'd0, busy}, {63'd0, m_cnt > 0});
            check_output("model_stall", {63'd0, stall},
                         {63'd0, (m_cnt > 0) && model_md(valid, funct, ALUOp)});
            check_output("model_hi", {32'd0, hi}, {32'd0, m_hi});
            check_output("model_lo", {32'd0, lo}, {32'd0, m_lo});
            check_output("model_mf_sel", {62'd0, mf_sel},
                         {62'd0, (ALUOp == 4'd0 && funct == 6'h10) ? 2'b01 :
                                 (ALUOp == 4'd0 && funct == 6'h12) ? 2'b10 : 2'b00});
            check_output("model_aluctrl", {60'd0, ALUCTRL}, {60'd0, exp_alu});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        check_output("reset_hi", {32'd0, hi}, 64'd0);
        check_output("reset_lo", {32'd0, lo}, 64'd0);
        check_output("reset_busy", {63'd0, busy}, 64'd0);
        check_output("reset_stall", {63'd0, stall}, 64'd0);

        apply_stimulus(1, FUNC_ADD, ALUOp_R, 32'd5, 32'd6, 4'd1);
        check_output("add_aluctrl", {60'd0, ALUCTRL}, 64'd1);
        check_output("add_shift", {63'd0, shift}, 64'd0);
        check_output("add_mf_sel", {62'd0, mf_sel}, 64'd0);
        check_output("add_stall", {63'd0, stall}, 64'd0);
        check_output("add_busy", {63'd0, busy}, 64'd0);
        step();
        apply_stimulus(1, FUNC_SUB, ALUOp_R, 32'd1, 32'd2, 4'd3);
        step();
        apply_stimulus(1, FUNC_SRA, ALUOp_R, 32'd1, 32'd2, 4'd13);
        check_output("sra_shift", {63'd0, shift}, 64'd1);
        step();
        apply_stimulus(1, FUNC_JALR, ALUOp_R, 32'd1, 32'd2, 4'd0);
        check_output("jalr_regtopc", {63'd0, RegtoPC}, 64'd1);
        check_output("jalr_regpcwr", {63'd0, RegPCWr}, 64'd1);
        step();
        apply_stimulus(1, FUNC_JR, ALUOp_R, 32'd1, 32'd2, 4'd0);
        check_output("jr_regpcwr", {63'd0, RegPCWr}, 64'd0);
        step();
        apply_stimulus(1, FUNC_ADD, ALUOp_OR, 32'd1, 32'd2, 4'd6);
        step();
        apply_stimulus(0, FUNC_MFLO, ALUOp_R, 32'd1, 32'd2, 4'd0);
        check_output("mflo_novalid_mf_sel", {62'd0, mf_sel}, 64'd2);
        step();
        apply_stimulus(1, 6'h3F, ALUOp_R, 32'd1, 32'd2, 4'd0);
        step();

        apply_stimulus(1, FUNC_MTHI, ALUOp_R, 32'h1234_5678, 32'd0, 4'd0);
        step();
        apply_stimulus(1, FUNC_MTLO, ALUOp_R, 32'h9ABC_DEF0, 32'd0, 4'd0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        check_output("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        check_output("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);

        apply_stimulus(1, FUNC_MULTU, ALUOp_R, 32'hFFFF_FFFF, 32'd2, 4'd0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        wait_busy(n);
        check_output("multu_busy_cycles", 64'(n), 64'd33);
        check_output("multu_hi", {32'd0, hi}, 64'h0000_0001);
        check_output("multu_lo", {32'd0, lo}, 64'hFFFF_FFFE);

        apply_stimulus(1, FUNC_MULT, ALUOp_R, 32'hFFFF_FFFD, 32'd5, 4'd0);
        step();
        apply_stimulus(1, FUNC_ADD, ALUOp_R, 32'd7, 32'd8, 4'd1);
        check_output("add_while_busy_stall", {63'd0, stall}, 64'd0);
        step();
        apply_stimulus(1, FUNC_MFHI, ALUOp_R, 32'd0, 32'd0, 4'd0);
        n = 0;
        while (busy && n < 100) begin
            check_output("mfhi_stall_busy", {63'd0, stall}, 64'd1);
            check_output("mfhi_mf_sel_busy", {62'd0, mf_sel}, 64'd1);
            rs_val = $urandom;
            rt_val = $urandom;
            step();
            n++;
        end
        check_output("mfhi_stall_after", {63'd0, stall}, 64'd0);
        check_output("mfhi_mf_sel_after", {62'd0, mf_sel}, 64'd1);
        check_output("mult_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check_output("mult_neg_lo", {32'd0, lo}, 64'hFFFF_FFF1);

        apply_stimulus(1, FUNC_MULT, ALUOp_R, 32'h8000_0000, 32'h8000_0000, 4'd0);
        step();
        apply_stimulus(1, FUNC_MULTU, ALUOp_R, 32'd7, 32'd9, 4'd0);
        wait_busy(n);
        check_output("mult_min_hi", {32'd0, hi}, 64'h4000_0000);
        check_output("mult_min_lo", {32'd0, lo}, 64'h0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        check_output("b2b_accepted_busy", {63'd0, busy}, 64'd1);
        wait_busy(n);
        check_output("b2b_lo", {32'd0, lo}, 64'd63);

`ifdef ALU_MD_DIV_EN
        apply_stimulus(1, FUNC_DIV, ALUOp_R, 32'hFFFF_FFF9, 32'd2, 4'd0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        wait_busy(n);
        check_output("div_busy_cycles", 64'(n), 64'd33);
        check_output("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check_output("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        apply_stimulus(1, FUNC_DIVU, ALUOp_R, 32'd5, 32'd0, 4'd0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        wait_busy(n);
        check_output("divu_zero_hi", {32'd0, hi}, 64'h5);
        check_output("divu_zero_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        apply_stimulus(1, FUNC_DIV, ALUOp_R, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        wait_busy(n);
        check_output("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
        check_output("div_ovf_hi", {32'd0, hi}, 64'h0);
        apply_stimulus(1, FUNC_DIV, ALUOp_R, 32'hFFFF_FFFB, 32'd0, 4'd0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        wait_busy(n);
        check_output("div_neg_zero_hi", {32'd0, hi}, 64'hFFFF_FFFB);
        apply_stimulus(1, FUNC_DIV, ALUOp_R, 32'd7, 32'hFFFF_FFFE, 4'd0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        wait_busy(n);
        apply_stimulus(1, FUNC_DIV, ALUOp_R, 32'd100, 32'd7, 4'd0);
`else
        apply_stimulus(1, FUNC_MULT, ALUOp_R, 32'd100, 32'd7, 4'd0);
`endif
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        repeat (9) step();
        check_output("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("midop_reset_busy", {63'd0, busy}, 64'd0);
        check_output("midop_reset_hi", {32'd0, hi}, 64'd0);
        check_output("midop_reset_lo", {32'd0, lo}, 64'd0);
        apply_stimulus(1, FUNC_MULT, ALUOp_R, 32'd3, 32'd4, 4'd0);
        step();
        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        wait_busy(n);
        check_output("after_reset_mult_lo", {32'd0, lo}, 64'd12);
        check_output("after_reset_mult_hi", {32'd0, hi}, 64'd0);

`ifndef ALU_MD_DIV_EN
        apply_stimulus(1, FUNC_DIV, ALUOp_R, 32'd20, 32'd3, 4'd0);
        check_output("nodiv_aluctrl", {60'd0, ALUCTRL}, 64'd0);
        check_output("nodiv_stall", {63'd0, stall}, 64'd0);
        repeat (3) begin
            step();
            check_output("nodiv_busy", {63'd0, busy}, 64'd0);
        end
        apply_stimulus(1, FUNC_DIVU, ALUOp_R, 32'd20, 32'd0, 4'd0);
        step();
        check_output("nodivu_busy", {63'd0, busy}, 64'd0);
        check_output("nodiv_hi", {32'd0, hi}, 64'd0);
        check_output("nodiv_lo", {32'd0, lo}, 64'd12);
`endif

        apply_stimulus(0, FUNC_ADD, ALUOp_R, 32'd0, 32'd0, 4'd1);
        step();
        step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
